redas_edge_feeder: RTL and testbench

- Producer side of the redas_pe neighbour interface, sitting on the top/right edge of a column of LANES PEs.
- Loads one stationary operand per lane: it drives the right-edge data and pulses store_stationary.
- Then streams operand vectors onto the top-edge data lines. Each vector is held HOLD_CYCLES cycles, and lane i is skewed by i vector slots for systolic alignment.
- Upstream side uses valid/ready handshakes; downstream PE side is unhandshaked, with timing set by this block.

---
 rtl/redas_pkg.sv | 21 ++
 rtl/redas_skew_line.sv | 33 +++
 rtl/redas_edge_feeder.sv | 149 ++++++++++++++
 tb/tb_redas_edge_feeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redas_pkg.sv
// Shared state type and lane-bus helpers for the redas edge feeder.
package redas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_e;

  function automatic int laneBusWidth(input int lanes, input int dataWidth);
    return lanes * dataWidth;
  endfunction

  function automatic int laneLsb(input int lane, input int dataWidth);
    return lane * dataWidth;
  endfunction

endpackage

// File: rtl/redas_skew_line.sv
// Slot-granular delay line: the output trails the input by DELAY advance events.
module redas_skew_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DELAY      = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_advance,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  if (DELAY == 0) begin : g_pass
    logic w_unused;
    assign w_unused = ^{i_clk, i_rst, i_clear, i_advance};
    assign o_data   = i_data;
  end else begin : g_shift
    logic [DATA_WIDTH-1:0] r_stage [DELAY];

    always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
        for (int k = 0; k < DELAY; k++) r_stage[k] <= '0;
      end else if (i_advance) begin
        r_stage[0] <= i_data;
        for (int k = 1; k < DELAY; k++) r_stage[k] <= r_stage[k-1];
      end
    end

    assign o_data = r_stage[DELAY-1];
  end

endmodule

// File: rtl/redas_edge_feeder.sv
// Edge feeder for a column of redas PEs: loads stationary operands on the right
// edge, then streams skewed activation vectors onto the top edge.
module redas_edge_feeder
  import redas_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_WIDTH   = 16,
  localparam int BUS_W      = laneBusWidth(LANES, DATA_WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_numVectors,
  input  logic                 i_wValid,
  output logic                 o_wReady,
  input  logic [BUS_W-1:0]     i_wData,
  input  logic                 i_aValid,
  output logic                 o_aReady,
  input  logic [BUS_W-1:0]     i_aData,
  output logic [BUS_W-1:0]     o_rightData,
  output logic [BUS_W-1:0]     o_topData,
  output logic                 o_storeStationary,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int FL_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [FL_W-1:0]   FLUSH_LAST = (LANES > 1) ? FL_W'(LANES - 2) : '0;

  feeder_state_e        r_state;
  feeder_state_e        w_nextState;
  logic [CNT_WIDTH-1:0] r_numVectors;
  logic [CNT_WIDTH-1:0] r_accCount;
  logic [CNT_WIDTH-1:0] w_accNext;
  logic [HOLD_W-1:0]    r_hold;
  logic [FL_W-1:0]      r_flushCount;
  logic                 r_store;
  logic [BUS_W-1:0]     r_rightData;
  logic [BUS_W-1:0]     r_slotVec;
  logic [BUS_W-1:0]     w_topData;
  logic                 w_wReady;
  logic                 w_aReady;
  logic                 w_wFire;
  logic                 w_accept;
  logic                 w_streamSlotEnd;
  logic                 w_flushAdvance;
  logic                 w_flushSlotEnd;
  logic                 w_advance;
  logic                 w_holdRun;
  logic                 w_clear;

  assign w_wFire         = w_wReady && i_wValid;
  assign w_accept        = w_aReady && i_aValid;
  assign w_accNext       = r_accCount + CNT_WIDTH'(w_accept);
  // A slot ends on its last hold cycle; with one-cycle slots that is the accept cycle itself.
  assign w_streamSlotEnd = (r_state == STREAM) && (r_hold == HOLD_LAST) &&
                           ((r_hold != '0) || w_accept);
  assign w_flushAdvance  = (r_state == FLUSH) && (r_hold == '0);
  assign w_flushSlotEnd  = (r_state == FLUSH) && (r_hold == HOLD_LAST);
  assign w_advance       = w_accept || w_flushAdvance;
  assign w_holdRun       = ((r_state == STREAM) && ((r_hold != '0) || w_accept)) ||
                           (r_state == FLUSH);
  assign w_clear         = (r_state == DONE);

  always_comb begin
    w_nextState = r_state;
    w_wReady    = 1'b0;
    w_aReady    = 1'b0;
    o_done      = 1'b0;
    o_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (i_start) w_nextState = LOAD;
      end
      LOAD: begin
        w_wReady = !r_store;
        if (r_store) w_nextState = SETTLE;
      end
      SETTLE: begin
        w_nextState = (r_numVectors == '0) ? FLUSH : STREAM;
      end
      STREAM: begin
        w_aReady = (r_hold == '0);
        if (w_streamSlotEnd && (w_accNext == r_numVectors)) w_nextState = FLUSH;
      end
      FLUSH: begin
        if ((LANES == 1) || (w_flushSlotEnd && (r_flushCount == FLUSH_LAST)))
          w_nextState = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_numVectors <= '0;
      r_accCount   <= '0;
      r_hold       <= '0;
      r_flushCount <= '0;
      r_store      <= 1'b0;
      r_rightData  <= '0;
      r_slotVec    <= '0;
    end else begin
      r_state <= w_nextState;
      r_store <= w_wFire;
      if ((r_state == IDLE) && i_start) r_numVectors <= i_numVectors;
      if (r_state == IDLE) r_accCount <= '0;
      else if (w_accept)   r_accCount <= w_accNext;
      if (w_holdRun) r_hold <= (r_hold == HOLD_LAST) ? '0 : r_hold + HOLD_W'(1);
      else           r_hold <= '0;
      if (r_state != FLUSH)    r_flushCount <= '0;
      else if (w_flushSlotEnd) r_flushCount <= r_flushCount + FL_W'(1);
      if (w_wFire) r_rightData <= i_wData;
      // Flush slots push zero vectors so the tail drains through the deeper lanes.
      if (r_state == DONE) r_slotVec <= '0;
      else if (w_advance)  r_slotVec <= w_accept ? i_aData : '0;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    redas_skew_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .DELAY     (g)
    ) u_skew (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (w_clear),
      .i_advance(w_advance),
      .i_data   (r_slotVec[laneLsb(g, DATA_WIDTH) +: DATA_WIDTH]),
      .o_data   (w_topData[laneLsb(g, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  assign o_wReady          = w_wReady;
  assign o_aReady          = w_aReady;
  assign o_rightData       = r_rightData;
  assign o_topData         = w_topData;
  assign o_storeStationary = r_store;

endmodule

// File: tb/tb_redas_edge_feeder.sv
// Directed bench for redas_edge_feeder: reset, stationary load, skew timing,
// backpressure, a lane-0 PE sum sweep and mid-stream abort.
module tb_redas_edge_feeder;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int H  = 2;
  localparam int CW = 16;
  localparam int BW = L * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] numVectors;
  logic          wValid;
  logic          wReady;
  logic [BW-1:0] wData;
  logic          aValid;
  logic          aReady;
  logic [BW-1:0] aData;
  logic [BW-1:0] rightData;
  logic [BW-1:0] topData;
  logic          storeStationary;
  logic          busy;
  logic          done;

  int assertCount = 0;
  int failCount   = 0;
  logic [BW-1:0] jobVecs [$];
  logic [BW-1:0] lastRight = '0;
  logic signed [DW-1:0] peW;

  redas_edge_feeder #(
    .DATA_WIDTH (DW),
    .LANES      (L),
    .HOLD_CYCLES(H),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .i_numVectors     (numVectors),
    .i_wValid         (wValid),
    .o_wReady         (wReady),
    .i_wData          (wData),
    .i_aValid         (aValid),
    .o_aReady         (aReady),
    .i_aData          (aData),
    .o_rightData      (rightData),
    .o_topData        (topData),
    .o_storeStationary(storeStationary),
    .o_busy           (busy),
    .o_done           (done)
  );

  always #5 clk = ~clk;

  // Lane-0 PE model: captures its stationary operand when store_stationary is high.
  always @(posedge clk) if (storeStationary) peW <= rightData[DW-1:0];

  task automatic applyStimulus(input logic rstV, input logic startV, input logic [CW-1:0] numV,
                               input logic wValidV, input logic [BW-1:0] wDataV,
                               input logic aValidV, input logic [BW-1:0] aDataV);
    rst        = rstV;
    start      = startV;
    numVectors = numV;
    wValid     = wValidV;
    wData      = wDataV;
    aValid     = aValidV;
    aData      = aDataV;
  endtask

  // Runs one job from jobVecs; cycle c is the c-th falling edge after start is driven.
  task automatic runJob(input string name, input logic [BW-1:0] wDataV, input int stallAt,
                        input int stallLen, input int abortAt, input bit peCheck,
                        input int peM, output int doneCycle);
    int n, avail, c, idx, s, j, flushEntry, doneAt, lastC;
    int advT [$];
    bit readyAt [int];
    logic [BW-1:0] expTop, expRight, aDataV;
    logic signed [DW-1:0] topLane0, vecLane0;
    bit aValidV, inStall, aborted;
    n = jobVecs.size();
    avail = 4;
    for (int k = 0; k < n; k++) begin
      c = avail;
      while (c >= stallAt && c < stallAt + stallLen) begin
        readyAt[c] = 1'b1;
        c++;
      end
      readyAt[c] = 1'b1;
      advT.push_back(c + 1);
      avail = c + H;
    end
    flushEntry = (n > 0) ? advT[n-1] + H - 1 : 4;
    for (int f = 0; f < L - 1; f++) advT.push_back(flushEntry + 1 + H * f);
    doneAt = advT[advT.size()-1] + H - 1;
    lastC = (abortAt >= 0) ? abortAt + 4 : doneAt + 2;
    doneCycle = -1;
    idx = 0;
    for (int cyc = 0; cyc <= lastC; cyc++) begin
      @(negedge clk);
      if (done === 1'b1 && doneCycle < 0) doneCycle = cyc;
      aborted = (abortAt >= 0) && (cyc > abortAt);
      s = -1;
      foreach (advT[k]) if (advT[k] <= cyc) s = k;
      expTop = '0;
      if (!aborted && cyc <= doneAt)
        for (int i = 0; i < L; i++) begin
          j = s - i;
          if (s >= 0 && j >= 0 && j < n) expTop[i*DW +: DW] = jobVecs[j][i*DW +: DW];
        end
      expRight = aborted ? '0 : ((cyc >= 2) ? wDataV : lastRight);

      assertCount++;
      if (topData !== expTop) begin
        failCount++;
        $display("[TB] FAIL %s top_data c=%0d got %h expected %h", name, cyc, topData, expTop);
      end
      assertCount++;
      if (rightData !== expRight) begin
        failCount++;
        $display("[TB] FAIL %s right_data c=%0d got %h expected %h", name, cyc, rightData, expRight);
      end
      assertCount++;
      if (storeStationary !== (!aborted && cyc == 2)) begin
        failCount++;
        $display("[TB] FAIL %s store_stationary c=%0d got %b", name, cyc, storeStationary);
      end
      assertCount++;
      if (done !== (!aborted && cyc == doneAt)) begin
        failCount++;
        $display("[TB] FAIL %s done c=%0d got %b expected pulse at %0d", name, cyc, done, doneAt);
      end
      assertCount++;
      if (busy !== (!aborted && cyc >= 1 && cyc <= doneAt)) begin
        failCount++;
        $display("[TB] FAIL %s busy c=%0d got %b", name, cyc, busy);
      end
      assertCount++;
      if (wReady !== (!aborted && cyc == 1)) begin
        failCount++;
        $display("[TB] FAIL %s w_ready c=%0d got %b", name, cyc, wReady);
      end
      assertCount++;
      if (aReady !== (!aborted && readyAt.exists(cyc))) begin
        failCount++;
        $display("[TB] FAIL %s a_ready c=%0d got %b", name, cyc, aReady);
      end
      if (peCheck && !aborted && s >= 0 && s < n && cyc <= doneAt) begin
        topLane0 = topData[DW-1:0];
        vecLane0 = jobVecs[s][DW-1:0];
        assertCount++;
        if (int'(topLane0) + int'(peW) != int'(vecLane0) + peM) begin
          failCount++;
          $display("[TB] FAIL %s pe_sum c=%0d got %0d expected %0d", name, cyc,
                   int'(topLane0) + int'(peW), int'(vecLane0) + peM);
        end
      end

      inStall = (cyc >= stallAt) && (cyc < stallAt + stallLen);
      aValidV = (idx < n) && !inStall && !aborted;
      aDataV  = '0;
      if (aValidV) aDataV = jobVecs[idx];
      applyStimulus((abortAt >= 0) && (cyc == abortAt), cyc == 0, CW'(n), cyc <= 1,
                    wDataV, aValidV, aDataV);
      if (aValidV && readyAt.exists(cyc)) idx++;
    end
    lastRight = (abortAt >= 0) ? '0 : wDataV;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 16'd5, 1'b1, '1, 1'b1, '1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      assertCount++;
      if ({topData, rightData} !== '0) begin
        failCount++;
        $display("[TB] FAIL reset data got top %h right %h expected 0", topData, rightData);
      end
      assertCount++;
      if ({storeStationary, busy, done, wReady, aReady} !== 5'b0) begin
        failCount++;
        $display("[TB] FAIL reset ctrl got %b expected 00000",
                 {storeStationary, busy, done, wReady, aReady});
      end
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    repeat (2) begin
      @(negedge clk);
      assertCount++;
      if ({busy, wReady, aReady, done} !== 4'b0) begin
        failCount++;
        $display("[TB] FAIL idle_after_reset got %b expected 0000", {busy, wReady, aReady, done});
      end
    end
  endtask

  task automatic test_stationary();
    int dc;
    jobVecs.delete();
    runJob("stationary", 32'h04030201, -1, 0, -1, 1'b0, 0, dc);
    assertCount++;
    if (dc != 10) begin
      failCount++;
      $display("[TB] FAIL stationary done_cycle got %0d expected 10", dc);
    end
  endtask

  task automatic test_skew();
    int dc;
    jobVecs = {32'h281E140A, 32'h291F150B, 32'h2A20160C};
    runJob("skew", 32'h11223344, -1, 0, -1, 1'b0, 0, dc);
    assertCount++;
    if (dc != 16) begin
      failCount++;
      $display("[TB] FAIL skew done_cycle got %0d expected 16", dc);
    end
  endtask

  task automatic test_backpressure();
    int dc;
    jobVecs = {32'h281E140A, 32'h291F150B, 32'h2A20160C};
    runJob("backpressure", 32'h55667788, 8, 5, -1, 1'b0, 0, dc);
    assertCount++;
    if (dc != 21) begin
      failCount++;
      $display("[TB] FAIL backpressure done_cycle got %0d expected 21", dc);
    end
  endtask

  task automatic test_pe_sum();
    int dc;
    logic [DW-1:0] b;
    for (int m = -10; m <= 9; m++) begin
      jobVecs.delete();
      for (int n = -10; n <= 9; n++) begin
        b = DW'(n);
        jobVecs.push_back({24'h0, b});
      end
      b = DW'(m);
      runJob("pe_sum", {24'h0, b}, -1, 0, -1, 1'b1, m, dc);
    end
  endtask

  task automatic test_abort();
    int dc;
    jobVecs = {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404,
               32'h05050505, 32'h06060606, 32'h07070707, 32'h08080808};
    runJob("abort", 32'h0A0B0C0D, -1, 0, 8, 1'b0, 0, dc);
    assertCount++;
    if (dc != -1) begin
      failCount++;
      $display("[TB] FAIL abort done_seen got cycle %0d expected none", dc);
    end
    jobVecs = {32'h281E140A, 32'h291F150B, 32'h2A20160C};
    runJob("after_abort", 32'h0F0E0D0C, -1, 0, -1, 1'b0, 0, dc);
    assertCount++;
    if (dc != 16) begin
      failCount++;
      $display("[TB] FAIL after_abort done_cycle got %0d expected 16", dc);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_stationary();
    test_skew();
    test_backpressure();
    test_pe_sum();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
